// File: rtl/draw_score.sv
// draw_score: renders a 4-digit decimal score into a frame buffer.
// The binary score is converted to BCD serially, then each digit's 8x8
// glyph is fetched row by row from an external ROM and written pixel by
// pixel through a stallable write port.
module draw_score #(
    parameter int         X0 = 8,
    parameter int         Y0 = 8,
    parameter logic [7:0] FG = 8'hFF,
    parameter logic [7:0] BG = 8'h00
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        draw_score_start,
    input  logic [13:0] score,
    output logic [6:0]  font_addr,
    input  logic [7:0]  font_data,
    output logic        fb_we,
    output logic [8:0]  fb_x,
    output logic [7:0]  fb_y,
    output logic [7:0]  fb_color,
    input  logic        fb_ack,
    output logic        busy,
    output logic        draw_score_done
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CONVERT,
        S_FETCH,
        S_WAIT_ROM,
        S_WRITE,
        S_DONE
    } state_t;

    state_t      r_state;
    logic [13:0] r_bin;
    logic [15:0] r_bcd;
    logic [3:0]  r_cnt;
    logic [1:0]  r_digit;
    logic [2:0]  r_row;
    logic [2:0]  r_col;
    logic [7:0]  r_rowbits;
    logic [6:0]  r_font_addr;
    logic        r_fb_we;
    logic [8:0]  r_fb_x;
    logic [7:0]  r_fb_y;
    logic [7:0]  r_fb_color;
    logic        r_busy;
    logic        r_done;

    logic [15:0] w_adj;
    logic [15:0] w_bcd_shift;
    logic [13:0] w_score_sat;
    logic [2:0]  w_col_inc;
    logic [2:0]  w_row_inc;
    logic [1:0]  w_digit_inc;
    logic [8:0]  w_x_base;
    logic [7:0]  w_y;

    // Select one BCD digit; digit 0 is the thousands place.
    function automatic logic [3:0] nib(input logic [15:0] b, input logic [1:0] d);
        case (d)
            2'd0:    nib = b[15:12];
            2'd1:    nib = b[11:8];
            2'd2:    nib = b[7:4];
            default: nib = b[3:0];
        endcase
    endfunction

    // Add-3 correction of every BCD nibble ahead of the next shift, plus
    // saturation and counter increments used by the FSM.
    always_comb begin
        w_adj = r_bcd;
        for (int unsigned i = 0; i < 4; i++) begin
            if (r_bcd[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
            end
        end
        w_bcd_shift = {w_adj[14:0], r_bin[13]};
        w_score_sat = (score > 14'd9999) ? 14'd9999 : score;
        w_col_inc   = r_col + 3'd1;
        w_row_inc   = r_row + 3'd1;
        w_digit_inc = r_digit + 2'd1;
        w_x_base    = 9'(X0) + {4'd0, r_digit, 3'd0};
        w_y         = 8'(Y0) + {5'd0, r_row};
    end

    // Control FSM with all outputs registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_bin       <= '0;
            r_bcd       <= '0;
            r_cnt       <= '0;
            r_digit     <= '0;
            r_row       <= '0;
            r_col       <= '0;
            r_rowbits   <= '0;
            r_font_addr <= '0;
            r_fb_we     <= 1'b0;
            r_fb_x      <= '0;
            r_fb_y      <= '0;
            r_fb_color  <= '0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (draw_score_start) begin
                        r_bin   <= w_score_sat;
                        r_bcd   <= '0;
                        r_cnt   <= '0;
                        r_digit <= '0;
                        r_row   <= '0;
                        r_col   <= '0;
                        r_busy  <= 1'b1;
                        r_state <= S_CONVERT;
                    end
                end
                S_CONVERT: begin
                    r_bcd <= w_bcd_shift;
                    r_bin <= {r_bin[12:0], 1'b0};
                    r_cnt <= r_cnt + 4'd1;
                    if (r_cnt == 4'd13) begin
                        // Address uses the freshly completed BCD value.
                        r_font_addr <= {w_bcd_shift[15:12], 3'd0};
                        r_digit     <= '0;
                        r_row       <= '0;
                        r_col       <= '0;
                        r_state     <= S_FETCH;
                    end
                end
                S_FETCH: begin
                    r_state <= S_WAIT_ROM;
                end
                S_WAIT_ROM: begin
                    r_rowbits  <= font_data;
                    r_fb_we    <= 1'b1;
                    r_fb_x     <= w_x_base;
                    r_fb_y     <= w_y;
                    r_fb_color <= font_data[7] ? FG : BG;
                    r_state    <= S_WRITE;
                end
                S_WRITE: begin
                    if (fb_ack) begin
                        if (r_col == 3'd7) begin
                            r_col   <= '0;
                            r_fb_we <= 1'b0;
                            if (r_row == 3'd7) begin
                                r_row <= '0;
                                if (r_digit == 2'd3) begin
                                    r_done  <= 1'b1;
                                    r_state <= S_DONE;
                                end else begin
                                    r_digit     <= w_digit_inc;
                                    r_font_addr <= {nib(r_bcd, w_digit_inc), 3'd0};
                                    r_state     <= S_FETCH;
                                end
                            end else begin
                                r_row       <= w_row_inc;
                                r_font_addr <= {nib(r_bcd, r_digit), w_row_inc};
                                r_state     <= S_FETCH;
                            end
                        end else begin
                            r_col      <= w_col_inc;
                            r_fb_x     <= r_fb_x + 9'd1;
                            r_fb_color <= r_rowbits[3'd6 - r_col] ? FG : BG;
                        end
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign font_addr       = r_font_addr;
    assign fb_we           = r_fb_we;
    assign fb_x            = r_fb_x;
    assign fb_y            = r_fb_y;
    assign fb_color        = r_fb_color;
    assign busy            = r_busy;
    assign draw_score_done = r_done;

endmodule

// File: tb/tb_draw_score.sv
// tb_draw_score: directed draws with a behavioural glyph ROM; every
// accepted pixel write is compared with the position/colour derived from
// the decimal digits of the score.
module tb_draw_score;

    logic        clk = 1'b0;
    logic        rst;
    logic        draw_score_start;
    logic [13:0] score;
    logic [6:0]  font_addr;
    logic [7:0]  font_data;
    logic        fb_we;
    logic [8:0]  fb_x;
    logic [7:0]  fb_y;
    logic [7:0]  fb_color;
    logic        fb_ack;
    logic        busy;
    logic        draw_score_done;

    int tests = 0;
    int fails = 0;

    logic [7:0] rom [0:127];

    always #5 clk = ~clk;

    draw_score #(.X0(8), .Y0(8), .FG(8'hFF), .BG(8'h00)) dut (
        .clk             (clk),
        .rst             (rst),
        .draw_score_start(draw_score_start),
        .score           (score),
        .font_addr       (font_addr),
        .font_data       (font_data),
        .fb_we           (fb_we),
        .fb_x            (fb_x),
        .fb_y            (fb_y),
        .fb_color        (fb_color),
        .fb_ack          (fb_ack),
        .busy            (busy),
        .draw_score_done (draw_score_done)
    );

    // One-cycle-latency glyph ROM
    always @(posedge clk) font_data <= rom[font_addr];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Decimal digit d (0 = thousands) of the saturated score
    function automatic int dval(input int s, input int d);
        int v;
        v = (s > 9999) ? 9999 : s;
        case (d)
            0:       return v / 1000;
            1:       return (v / 100) % 10;
            2:       return (v / 10) % 10;
            default: return v % 10;
        endcase
    endfunction

    // mode 0: ack high; 1: random stalls; 2: spurious starts mid-draw and in DONE;
    // 3: reset during digit 2
    task automatic run_draw(input int sc, input int mode, input string name);
        int t, n, dones, stall_left, budget, done_t;
        int d, r, c, a, last_x, last_y;
        logic prev_we, prev_ack;
        logic [8:0] px;
        logic [7:0] py, pc, g;
        @(negedge clk);
        score = 14'(sc);
        draw_score_start = 1'b1;
        fb_ack = (mode == 1) ? 1'b0 : 1'b1;
        @(negedge clk);
        draw_score_start = 1'b0;
        score = 14'($urandom);
        t = 0; n = 0; dones = 0; stall_left = 0; done_t = -1;
        last_x = 0; last_y = 0;
        prev_we = 1'b0; prev_ack = 1'b1; px = '0; py = '0; pc = '0;
        budget = (mode == 1) ? 3000 : ((mode == 3) ? 200 : 345);
        check({name, ".busy_rise"}, 32'(busy), 32'd1);
        while (t < budget) begin
            if (t < 14) check({name, ".we_conv"}, 32'(fb_we), 32'd0);
            if (draw_score_done) begin
                dones++;
                done_t = t;
                if (mode != 1) check({name, ".done_time"}, t, 334);
            end
            if (mode != 1 && t >= 14 && (t - 14) % 10 == 0 && (t - 14) / 10 < 32
                && !(mode == 3 && t > 178)) begin
                r = (t - 14) / 10;
                check({name, ".font_addr"}, 32'(font_addr), 32'(dval(sc, r / 8) * 8 + r % 8));
            end
            if ((mode == 0 || mode == 2) && t == 335)
                check({name, ".busy_fall"}, 32'(busy), 32'd0);
            if (prev_we && !prev_ack) begin
                check({name, ".stall_we"}, 32'(fb_we), 32'd1);
                check({name, ".stall_pix"}, {7'd0, fb_x, fb_y, fb_color}, {7'd0, px, py, pc});
            end
            if (mode == 3 && t == 179) begin
                check({name, ".rst_we"}, 32'(fb_we), 32'd0);
                check({name, ".rst_busy"}, 32'(busy), 32'd0);
                check({name, ".rst_outs"}, {font_addr, fb_x, fb_y, fb_color}, 32'd0);
                rst = 1'b0;
            end
            if (mode == 3 && t == 178) begin
                check({name, ".pre_rst_we"}, 32'(fb_we), 32'd1);
                rst = 1'b1;
            end
            if (mode == 1) begin
                if (fb_we) begin
                    if (!prev_we || prev_ack) stall_left = $urandom_range(0, 5);
                    fb_ack = (stall_left == 0);
                    if (stall_left > 0) stall_left--;
                end else begin
                    fb_ack = 1'($urandom);
                end
            end
            if (fb_we && fb_ack && !(mode == 3 && t >= 178)) begin
                if (n < 256) begin
                    d = n / 64; r = (n / 8) % 8; c = n % 8;
                    a = dval(sc, d) * 8 + r;
                    g = rom[a];
                    check({name, ".x"}, 32'(fb_x), 32'(8 + 8 * d + c));
                    check({name, ".y"}, 32'(fb_y), 32'(8 + r));
                    check({name, ".color"}, 32'(fb_color), g[7 - c] ? 32'hFF : 32'h00);
                end
                n++;
                last_x = int'(fb_x);
                last_y = int'(fb_y);
            end
            prev_we = fb_we; prev_ack = fb_ack;
            px = fb_x; py = fb_y; pc = fb_color;
            if (mode == 2) begin
                draw_score_start = (t == 100 || t == 334);
                if (t == 100) score = 14'd55;
            end
            if (mode == 1 && done_t >= 0 && t >= done_t + 5) break;
            @(negedge clk);
            t++;
        end
        draw_score_start = 1'b0;
        if (mode == 3) begin
            check({name, ".no_done"}, dones, 0);
        end else begin
            check({name, ".writes"}, n, 256);
            check({name, ".dones"}, dones, 1);
            check({name, ".last_x"}, last_x, 39);
            check({name, ".last_y"}, last_y, 15);
        end
        fb_ack = 1'b1;
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 128; i++) rom[i] = 8'($urandom);
        rst = 1'b1;
        draw_score_start = 1'b0;
        score = '0;
        fb_ack = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.outs", {font_addr, fb_x, fb_y, fb_color}, 32'd0);
        check("rst.ctrl", {29'd0, fb_we, busy, draw_score_done}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle.ctrl", {29'd0, fb_we, busy, draw_score_done}, 32'd0);

        run_draw(1234, 0, "d1234");
        run_draw(12000, 0, "d12000");
        run_draw(1234, 1, "stall1234");
        run_draw(1234, 2, "midstart");
        run_draw(1234, 3, "abort");
        run_draw(7, 0, "d7");
        run_draw(9999, 1, "stall9999");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
